// File: rtl/sample_unpacker_if.sv
// Byte-wide FIFO read-side handshake shared by the FIFO and its consumer.
// Latency: none (wires only).
// Backpressure: consumer drives ready as the FIFO read enable; data/valid come from the FIFO.
interface FIFOInterface #(
    parameter int Nb = 8
);
    logic [Nb-1:0] data;
    logic          valid;
    logic          ready;

    // Consumer side: sees FIFO data/valid, returns the read enable.
    modport consumer (input data, input valid, output ready);
    // Producer side: the FIFO itself.
    modport producer (output data, output valid, input ready);
endinterface

// File: rtl/sample_unpacker.sv
// Reassembles MSB-first byte streams into Bytes-wide samples tagged with channel and frame-last.
// Latency: out_valid rises on the edge after the final byte of a sample is accepted.
// Backpressure: non-final bytes always accepted; final byte stalls while the output register is held.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   in              - byte stream from the FIFO (data/valid in, ready = read enable out)
//   resync          - synchronous: drop partial sample and pending output, restart at channel 0
//   out_data        - assembled sample, first byte in the MSBs
//   out_channel     - channel index of out_data
//   out_last        - out_channel is the last channel of the frame
//   out_valid/ready - registered output handshake
//   busy            - a partial sample is held
module sample_unpacker #(
    parameter int Nb    = 8,
    parameter int Bytes = 3,
    parameter int Nch   = 2,
    parameter int Cw    = (Nch > 1) ? $clog2(Nch) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    FIFOInterface.consumer        in,
    input  logic                  resync,
    output logic [Nb*Bytes-1:0]   out_data,
    output logic [Cw-1:0]         out_channel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int            Kw      = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam logic [Kw-1:0] K_LAST  = Kw'(Bytes - 1);
    localparam logic [Cw-1:0] CH_LAST = Cw'(Nch - 1);

    logic [Kw-1:0]       k;
    logic [Cw-1:0]       ch;
    logic                k_last;
    logic                accept;
    logic                final_accept;
    logic [Nb*Bytes-1:0] sample_next;

    assign k_last = (k == K_LAST);

    // The final byte may only enter when the output register is empty or
    // being emptied this cycle; resync blocks reads so its cycle loses no byte.
    assign in.ready     = !resync && (!k_last || !out_valid || out_ready);
    assign accept       = in.valid && in.ready;
    assign final_accept = accept && k_last;
    assign busy         = (k != '0);

    // Accumulator only exists for multi-byte samples; it holds the first
    // Bytes-1 bytes so the final byte completes the sample combinationally.
    generate
        if (Bytes > 1) begin : g_acc
            logic [Nb*(Bytes-1)-1:0] acc;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc <= '0;
                end else if (accept && !k_last) begin
                    // Shift left by one byte; the oldest byte falls off the top.
                    acc <= (Nb*(Bytes-1))'({acc, in.data});
                end
            end

            assign sample_next = {acc, in.data};
        end else begin : g_noacc
            assign sample_next = in.data;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k           <= '0;
            ch          <= '0;
            out_data    <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
        end else if (resync) begin
            // Pending output is dropped even if downstream is ready this cycle.
            k         <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
        end else begin
            if (final_accept) begin
                out_data    <= sample_next;
                out_channel <= ch;
                out_last    <= (ch == CH_LAST);
                out_valid   <= 1'b1;
                k           <= '0;
                ch          <= (ch == CH_LAST) ? '0 : ch + Cw'(1);
            end else begin
                if (accept) begin
                    k <= k + Kw'(1);
                end
                // A new final byte on the same edge keeps out_valid high (no bubble).
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_unpacker.sv
// Directed bench for sample_unpacker: 3-byte/2-channel and 1-byte/3-channel instances.
// Latency: n/a.
// Backpressure: out_ready driven per test.
module tb_sample_unpacker;
    logic        clk = 1'b0;
    logic        reset;
    logic        resync_a, resync_b;
    logic        ready_a, ready_b;
    logic [23:0] data_a;
    logic [7:0]  data_b;
    logic [0:0]  ch_a;
    logic [1:0]  ch_b;
    logic        last_a, last_b, valid_a, valid_b, busy_a, busy_b;

    FIFOInterface #(.Nb(8)) fa ();
    FIFOInterface #(.Nb(8)) fb ();

    sample_unpacker #(.Nb(8), .Bytes(3), .Nch(2)) u_a (
        .clk(clk), .reset(reset), .in(fa), .resync(resync_a),
        .out_data(data_a), .out_channel(ch_a), .out_last(last_a),
        .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a)
    );

    sample_unpacker #(.Nb(8), .Bytes(1), .Nch(3)) u_b (
        .clk(clk), .reset(reset), .in(fb), .resync(resync_b),
        .out_data(data_b), .out_channel(ch_b), .out_last(last_b),
        .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int vcnt_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        int          ch;
        logic        last;
        int          cyc;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];

    // Record every output transfer (sampled mid-cycle, away from the edge).
    always @(negedge clk) begin
        if (valid_a) vcnt_a++;
        if (valid_a && ready_a && !resync_a && !reset)
            qa.push_back('{data_a, int'(ch_a), last_a, cyc});
        if (valid_b && ready_b && !resync_b && !reset)
            qb.push_back('{{16'h0, data_b}, int'(ch_b), last_b, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until the DUT takes it (bounded wait).
    task automatic send(input int which, input logic [7:0] b);
        logic r;
        int   n;
        n = 0;
        if (which == 0) begin fa.valid = 1'b1; fa.data = b; end
        else            begin fb.valid = 1'b1; fb.data = b; end
        do begin
            @(negedge clk);
            r = (which == 0) ? fa.ready : fb.ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) chk("send_accept", r, 1);
    endtask

    task automatic idle(input int n);
        fa.valid = 1'b0;
        fb.valid = 1'b0;
        step(n);
    endtask

    task automatic pop(input int which, input string tag,
                       input logic [23:0] d, input int ch, input logic last);
        rec_t r;
        if (which == 0) begin
            if (qa.size() == 0) return;
            r = qa.pop_front();
        end else begin
            if (qb.size() == 0) return;
            r = qb.pop_front();
        end
        chk({tag, "_data"}, r.d, d);
        chk({tag, "_ch"}, r.ch, ch);
        chk({tag, "_last"}, r.last, last);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_ch"}, ch_a, 0);
        chk({tag, "_last"}, last_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        reset    = 1'b1;
        resync_a = 1'b0;
        resync_b = 1'b0;
        ready_a  = 1'b1;
        ready_b  = 1'b1;
        fa.valid = 1'b0; fa.data = 8'h00;
        fb.valid = 1'b0; fb.data = 8'h00;

        // Reset state
        @(negedge clk);
        check_zero_a("rst_a");
        chk("rst_b_valid", valid_b, 0);
        chk("rst_b_data", data_b, 0);
        chk("rst_b_busy", busy_b, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: two samples back-to-back, out_ready high
        send(0, 8'h12); send(0, 8'h34); send(0, 8'h56);
        c0 = cyc;
        send(0, 8'hAB); send(0, 8'hCD); send(0, 8'hEF);
        idle(5);
        chk("t1_count", qa.size(), 2);
        chk("t1_pulses", vcnt_a, 2);
        if (qa.size() == 2) begin
            chk("t1_latency", qa[0].cyc, c0);
            chk("t1_spacing", qa[1].cyc - qa[0].cyc, 3);
        end
        pop(0, "t1_s0", 24'h123456, 0, 1'b0);
        pop(0, "t1_s1", 24'hABCDEF, 1, 1'b1);

        // T2: downstream stalls 10 cycles after first sample
        send(0, 8'h12); send(0, 8'h34); send(0, 8'h56);
        ready_a = 1'b0;
        send(0, 8'hAB); send(0, 8'hCD);
        fa.data = 8'hEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) begin
                chk("t2_stall_ready", fa.ready, 0);
                chk("t2_hold_data", data_a, 24'h123456);
                chk("t2_hold_valid", valid_a, 1);
                chk("t2_hold_busy", busy_a, 1);
            end
            @(posedge clk); #1;
        end
        ready_a = 1'b1;
        @(negedge clk);
        chk("t2_release_ready", fa.ready, 1);
        @(posedge clk); #1;
        fa.valid = 1'b0;
        @(negedge clk);
        chk("t2_nobubble_valid", valid_a, 1);
        chk("t2_next_data", data_a, 24'hABCDEF);
        @(posedge clk); #1;
        idle(3);
        chk("t2_count", qa.size(), 2);
        pop(0, "t2_s0", 24'h123456, 0, 1'b0);
        pop(0, "t2_s1", 24'hABCDEF, 1, 1'b1);

        // T3: 12 continuous bytes
        for (int i = 1; i <= 12; i++) send(0, 8'(i));
        idle(4);
        chk("t3_count", qa.size(), 4);
        if (qa.size() == 4)
            for (int i = 1; i < 4; i++) chk("t3_spacing", qa[i].cyc - qa[i-1].cyc, 3);
        pop(0, "t3_s0", 24'h010203, 0, 1'b0);
        pop(0, "t3_s1", 24'h040506, 1, 1'b1);
        pop(0, "t3_s2", 24'h070809, 0, 1'b0);
        pop(0, "t3_s3", 24'h0A0B0C, 1, 1'b1);

        // T4: FIFO empty mid-sample
        send(0, 8'h11); send(0, 8'h22);
        fa.valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10 || i == 19) begin
                chk("t4_gap_busy", busy_a, 1);
                chk("t4_gap_valid", valid_a, 0);
            end
            @(posedge clk); #1;
        end
        send(0, 8'h33);
        idle(3);
        chk("t4_count", qa.size(), 1);
        pop(0, "t4_s0", 24'h112233, 0, 1'b0);

        // T5: resync drops partial sample, pending output and channel
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        ready_a = 1'b0;
        send(0, 8'h11); send(0, 8'h22);
        fa.valid = 1'b0;
        ready_a  = 1'b1;
        resync_a = 1'b1;
        @(negedge clk);
        chk("t5_resync_ready", fa.ready, 0);
        @(posedge clk); #1;
        resync_a = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy_a, 0);
        chk("t5_valid", valid_a, 0);
        @(posedge clk); #1;
        send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
        idle(3);
        chk("t5_count", qa.size(), 1);
        pop(0, "t5_s0", 24'hAABBCC, 0, 1'b0);

        // T5b: same with asynchronous reset
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        ready_a = 1'b0;
        send(0, 8'h11); send(0, 8'h22);
        fa.valid = 1'b0;
        reset = 1'b1;
        #2;
        check_zero_a("t5r_in_reset");
        @(posedge clk); #1;
        reset   = 1'b0;
        ready_a = 1'b1;
        send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
        idle(3);
        chk("t5r_count", qa.size(), 1);
        pop(0, "t5r_s0", 24'hAABBCC, 0, 1'b0);

        // T6: Bytes=1, Nch=3 instance
        for (int i = 1; i <= 6; i++) send(1, 8'(i));
        idle(3);
        chk("t6_count", qb.size(), 6);
        if (qb.size() == 6)
            for (int i = 1; i < 6; i++) chk("t6_spacing", qb[i].cyc - qb[i-1].cyc, 1);
        pop(1, "t6_s0", 24'h01, 0, 1'b0);
        pop(1, "t6_s1", 24'h02, 1, 1'b0);
        pop(1, "t6_s2", 24'h03, 2, 1'b1);
        pop(1, "t6_s3", 24'h04, 0, 1'b0);
        pop(1, "t6_s4", 24'h05, 1, 1'b0);
        pop(1, "t6_s5", 24'h06, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
